// File: rtl/hazard_ctrl.sv
// Scoreboard issue controller between decode and ID/EX: tracks pending destination
// registers, stalls on RAW/WAW or in-flight cap, and sequences flushes after redirects.
module hazard_ctrl #(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter bit          WB_BYPASS    = 1'b1
) (
  input  logic        clk_i,
  input  logic        n_rst,
  input  logic        dec_valid_i,
  input  logic [4:0]  dec_rs1_i,
  input  logic [4:0]  dec_rs2_i,
  input  logic        dec_rs1_used_i,
  input  logic        dec_rs2_used_i,
  input  logic [4:0]  dec_rd_i,
  input  logic        dec_wb_en_i,
  input  logic        retire_i,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        redirect_i,
  output logic        issue_o,
  output logic        stall_o,
  output logic        bubble_o,
  output logic        flush_o,
  output logic [31:0] busy_o,
  output logic [3:0]  inflight_o,
  output logic        error_o
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [3:0] CNT_MAX   = 4'(MAX_INFLIGHT);

  state_t      state;
  logic [2:0]  fcnt;
  logic [31:0] busy;
  logic [3:0]  count;
  logic        error;

  logic [31:0] bypass_mask;
  logic [31:0] eb;
  logic        hazard;
  logic        issue;
  logic        set_en;
  logic        clr_en;
  logic        err_evt;
  logic [31:0] busy_nxt;
  logic [3:0]  count_nxt;

  always_comb begin
    bypass_mask = '0;
    if (WB_BYPASS && retire_i && wb_en_i)
      bypass_mask = 32'd1 << wb_rd_i;
    eb = busy & ~bypass_mask;

    hazard = (dec_rs1_used_i & eb[dec_rs1_i])
           | (dec_rs2_used_i & eb[dec_rs2_i])
           | (dec_wb_en_i & (dec_rd_i != 5'd0) & eb[dec_rd_i])
           | ((count == CNT_MAX) & ~retire_i);

    issue    = 1'b0;
    issue_o  = 1'b0;
    stall_o  = 1'b0;
    bubble_o = 1'b0;
    flush_o  = 1'b0;
    if (n_rst) begin
      case (state)
        ST_RUN: begin
          issue    = dec_valid_i & ~hazard & ~redirect_i;
          issue_o  = issue;
          stall_o  = dec_valid_i & hazard & ~redirect_i;
          bubble_o = ~issue;
          flush_o  = redirect_i;
        end
        default: begin
          bubble_o = 1'b1;
          flush_o  = 1'b1;
        end
      endcase
    end
  end

  // Clear is applied before set so a same-index set/clear leaves the bit pending.
  always_comb begin
    set_en   = issue & dec_wb_en_i & (dec_rd_i != 5'd0);
    clr_en   = retire_i & wb_en_i & (wb_rd_i != 5'd0);
    busy_nxt = busy;
    if (clr_en) busy_nxt[wb_rd_i]  = 1'b0;
    if (set_en) busy_nxt[dec_rd_i] = 1'b1;
    busy_nxt[0] = 1'b0;

    err_evt = (retire_i & (count == 4'd0)) | (clr_en & ~busy[wb_rd_i]);

    count_nxt = count;
    if (issue && !retire_i)
      count_nxt = count + 4'd1;
    else if (!issue && retire_i && count != 4'd0)
      count_nxt = count - 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst) begin
      state <= ST_RUN;
      fcnt  <= '0;
      busy  <= '0;
      count <= '0;
      error <= 1'b0;
    end else begin
      busy  <= busy_nxt;
      count <= count_nxt;
      if (err_evt) error <= 1'b1;
      case (state)
        ST_RUN: begin
          if (redirect_i) begin
            state <= ST_FLUSH;
            fcnt  <= FCNT_LOAD;
          end
        end
        default: begin
          if (redirect_i)
            fcnt <= FCNT_LOAD;
          else if (fcnt == 3'd0)
            state <= ST_RUN;
          else
            fcnt <= fcnt - 3'd1;
        end
      endcase
    end
  end

  assign busy_o     = busy;
  assign inflight_o = count;
  assign error_o    = error;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle expectations are queued by the driver
// and checked by an independent monitor on the falling edge.
module tb_hazard_ctrl;

  logic        clk;
  logic        n_rst;
  logic        dec_valid, rs1_used, rs2_used, dec_wb_en;
  logic [4:0]  rs1, rs2, dec_rd;
  logic        retire, wb_en, redirect;
  logic [4:0]  wb_rd;

  logic        issue, stall, bubble, flush, error;
  logic [31:0] busy;
  logic [3:0]  inflight;

  logic        issue0, stall0, bubble0, flush0, error0;
  logic [31:0] busy0;
  logic [3:0]  inflight0;

  hazard_ctrl #(.MAX_INFLIGHT(4), .FLUSH_CYCLES(2), .WB_BYPASS(1'b1)) dut (
    .clk_i(clk), .n_rst(n_rst),
    .dec_valid_i(dec_valid), .dec_rs1_i(rs1), .dec_rs2_i(rs2),
    .dec_rs1_used_i(rs1_used), .dec_rs2_used_i(rs2_used),
    .dec_rd_i(dec_rd), .dec_wb_en_i(dec_wb_en),
    .retire_i(retire), .wb_en_i(wb_en), .wb_rd_i(wb_rd),
    .redirect_i(redirect),
    .issue_o(issue), .stall_o(stall), .bubble_o(bubble), .flush_o(flush),
    .busy_o(busy), .inflight_o(inflight), .error_o(error)
  );

  hazard_ctrl #(.MAX_INFLIGHT(4), .FLUSH_CYCLES(2), .WB_BYPASS(1'b0)) dut_nobyp (
    .clk_i(clk), .n_rst(n_rst),
    .dec_valid_i(dec_valid), .dec_rs1_i(rs1), .dec_rs2_i(rs2),
    .dec_rs1_used_i(rs1_used), .dec_rs2_used_i(rs2_used),
    .dec_rd_i(dec_rd), .dec_wb_en_i(dec_wb_en),
    .retire_i(retire), .wb_en_i(wb_en), .wb_rd_i(wb_rd),
    .redirect_i(redirect),
    .issue_o(issue0), .stall_o(stall0), .bubble_o(bubble0), .flush_o(flush0),
    .busy_o(busy0), .inflight_o(inflight0), .error_o(error0)
  );

  typedef struct {
    int          cyc;
    logic        iss, stl, bub, fl;
    logic [31:0] busy;
    logic [3:0]  inf;
    logic        err;
    logic        chk0, iss0, stl0;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic chk0_n, iss0_n, stl0_n;
  logic stim_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, exp);
    end
  endtask

  // Monitor: compares every cycle for which the driver queued an expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("issue",    e.cyc, {31'd0, issue},    {31'd0, e.iss});
        chk("stall",    e.cyc, {31'd0, stall},    {31'd0, e.stl});
        chk("bubble",   e.cyc, {31'd0, bubble},   {31'd0, e.bub});
        chk("flush",    e.cyc, {31'd0, flush},    {31'd0, e.fl});
        chk("busy",     e.cyc, busy,              e.busy);
        chk("inflight", e.cyc, {28'd0, inflight}, {28'd0, e.inf});
        chk("error",    e.cyc, {31'd0, error},    {31'd0, e.err});
        if (e.chk0) begin
          chk("issue_nobyp", e.cyc, {31'd0, issue0}, {31'd0, e.iss0});
          chk("stall_nobyp", e.cyc, {31'd0, stall0}, {31'd0, e.stl0});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    n_rst = 1'b1;
    dec_valid = 1'b0; rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    dec_rd = '0; dec_wb_en = 1'b0;
    retire = 1'b0; wb_en = 1'b0; wb_rd = '0; redirect = 1'b0;
    chk0_n = 1'b0; iss0_n = 1'b0; stl0_n = 1'b0;
  endtask

  task automatic expect_cyc(input logic i, input logic s, input logic b, input logic f,
                            input logic [31:0] bz, input logic [3:0] inf, input logic er);
    exp_t e;
    e.cyc = cyc; e.iss = i; e.stl = s; e.bub = b; e.fl = f;
    e.busy = bz; e.inf = inf; e.err = er;
    e.chk0 = chk0_n; e.iss0 = iss0_n; e.stl0 = stl0_n;
    q.push_back(e);
  endtask

  task automatic dec(input logic [4:0] rd, input logic wen);
    dec_valid = 1'b1; dec_rd = rd; dec_wb_en = wen;
  endtask

  task automatic ret(input logic wen, input logic [4:0] rd);
    retire = 1'b1; wb_en = wen; wb_rd = rd;
  endtask

  initial begin
    n_rst = 1'b0;
    dec_valid = 1'b0; rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    dec_rd = '0; dec_wb_en = 1'b0;
    retire = 1'b0; wb_en = 1'b0; wb_rd = '0; redirect = 1'b0;

    // Reset for two cycles, then idle
    tick(); n_rst = 1'b0;
    tick(); n_rst = 1'b0;                expect_cyc(0,0,0,0, 32'h0, 0, 0);
    tick();                              expect_cyc(0,0,1,0, 32'h0, 0, 0);

    // RAW with bypass; the non-bypass instance issues one cycle later
    tick(); dec(5'd5, 1); chk0_n = 1; iss0_n = 1; stl0_n = 0;
                                         expect_cyc(1,0,0,0, 32'h0, 0, 0);
    tick(); dec(5'd6, 1); rs1 = 5'd5; rs1_used = 1; chk0_n = 1; iss0_n = 0; stl0_n = 1;
                                         expect_cyc(0,1,1,0, 32'h20, 1, 0);
    tick(); dec(5'd6, 1); rs1 = 5'd5; rs1_used = 1; ret(1, 5'd5);
            chk0_n = 1; iss0_n = 0; stl0_n = 1;
                                         expect_cyc(1,0,0,0, 32'h20, 1, 0);
    tick(); dec(5'd6, 1); rs1 = 5'd5; rs1_used = 1; chk0_n = 1; iss0_n = 1; stl0_n = 0;
                                         expect_cyc(0,1,1,0, 32'h40, 1, 0);
    tick(); n_rst = 1'b0;                expect_cyc(0,0,0,0, 32'h40, 1, 0);
    tick();                              expect_cyc(0,0,1,0, 32'h0, 0, 0);

    // x0 never goes busy; WAW on x7 stalls until x7 retires, set wins on same index
    tick(); dec(5'd0, 1);                expect_cyc(1,0,0,0, 32'h0, 0, 0);
    tick(); dec(5'd7, 1);                expect_cyc(1,0,0,0, 32'h0, 1, 0);
    tick(); dec(5'd7, 1);                expect_cyc(0,1,1,0, 32'h80, 2, 0);
    tick(); dec(5'd7, 1); ret(0, 5'd0);  expect_cyc(0,1,1,0, 32'h80, 2, 0);
    tick(); dec(5'd7, 1); ret(1, 5'd7);  expect_cyc(1,0,0,0, 32'h80, 1, 0);
    tick();                              expect_cyc(0,0,1,0, 32'h80, 1, 0);
    tick(); ret(1, 5'd7);                expect_cyc(0,0,1,0, 32'h80, 1, 0);
    tick();                              expect_cyc(0,0,1,0, 32'h0, 0, 0);

    // In-flight cap of 4
    tick(); dec(5'd1, 1);                expect_cyc(1,0,0,0, 32'h0, 0, 0);
    tick(); dec(5'd2, 1);                expect_cyc(1,0,0,0, 32'h2, 1, 0);
    tick(); dec(5'd3, 1);                expect_cyc(1,0,0,0, 32'h6, 2, 0);
    tick(); dec(5'd4, 1);                expect_cyc(1,0,0,0, 32'hE, 3, 0);
    tick(); dec(5'd8, 1);                expect_cyc(0,1,1,0, 32'h1E, 4, 0);
    tick(); dec(5'd8, 1); ret(1, 5'd1);  expect_cyc(1,0,0,0, 32'h1E, 4, 0);
    tick();                              expect_cyc(0,0,1,0, 32'h11C, 4, 0);
    tick(); n_rst = 1'b0;                expect_cyc(0,0,0,0, 32'h11C, 4, 0);
    tick();                              expect_cyc(0,0,1,0, 32'h0, 0, 0);

    // Lone redirect: three suppressed cycles, scoreboard untouched
    tick(); dec(5'd5, 1);                expect_cyc(1,0,0,0, 32'h0, 0, 0);
    tick(); dec(5'd9, 1); redirect = 1;  expect_cyc(0,0,1,1, 32'h20, 1, 0);
    tick(); dec(5'd9, 1);                expect_cyc(0,0,1,1, 32'h20, 1, 0);
    tick(); dec(5'd9, 1);                expect_cyc(0,0,1,1, 32'h20, 1, 0);
    tick(); dec(5'd9, 0);                expect_cyc(1,0,0,0, 32'h20, 1, 0);

    // Second redirect in the second suppressed cycle extends flush through cycle 4
    tick(); dec(5'd9, 0); redirect = 1;  expect_cyc(0,0,1,1, 32'h20, 2, 0);
    tick(); dec(5'd9, 0); redirect = 1;  expect_cyc(0,0,1,1, 32'h20, 2, 0);
    tick(); dec(5'd9, 0);                expect_cyc(0,0,1,1, 32'h20, 2, 0);
    tick(); dec(5'd9, 0);                expect_cyc(0,0,1,1, 32'h20, 2, 0);
    tick(); dec(5'd9, 0);                expect_cyc(1,0,0,0, 32'h20, 2, 0);
    tick();                              expect_cyc(0,0,1,0, 32'h20, 3, 0);
    tick(); n_rst = 1'b0;                expect_cyc(0,0,0,0, 32'h20, 3, 0);
    tick();                              expect_cyc(0,0,1,0, 32'h0, 0, 0);

    // Retire with nothing in flight sets a sticky error
    tick(); ret(0, 5'd0);                expect_cyc(0,0,1,0, 32'h0, 0, 0);
    tick();                              expect_cyc(0,0,1,0, 32'h0, 0, 1);
    tick();                              expect_cyc(0,0,1,0, 32'h0, 0, 1);

    // Reset while flushing with x5 pending
    tick(); dec(5'd5, 1);                expect_cyc(1,0,0,0, 32'h0, 0, 1);
    tick(); redirect = 1;                expect_cyc(0,0,1,1, 32'h20, 1, 1);
    tick(); n_rst = 1'b0;                expect_cyc(0,0,0,0, 32'h20, 1, 1);
    tick(); dec(5'd9, 1);                expect_cyc(1,0,0,0, 32'h0, 0, 0);

    // Retire of a register that is not pending
    tick(); ret(1, 5'd3);                expect_cyc(0,0,1,0, 32'h200, 1, 0);
    tick();                              expect_cyc(0,0,1,0, 32'h200, 0, 1);

    tick();
    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required stimulus completion");
    $fatal(1, "watchdog");
  end

endmodule
